// File: rtl/robot_controller.sv
// robot_controller: left-hand wall-follower driving the map/robot datapath.
// Issues one-cycle advance/rotate pulses and a held remove command, and
// separates consecutive commands with a WAIT cycle so map sensors can settle.
// Optional build macro ROBOT_CTRL_SINGLE_STEP_EN adds a 'step' input that
// gates each SENSE decision (one decision plus its command sequence per pulse).
module robot_controller #(
  parameter int unsigned MAX_STEPS         = 255,
  parameter int unsigned MAX_REMOVE_CYCLES = 15
) (
  input  logic       Clock50,
  input  logic       Reset,
  input  logic       start,
`ifdef ROBOT_CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic       head_in,
  input  logic       left_in,
  input  logic       under_in,
  input  logic       barrier_in,
  output logic       avancar,
  output logic       girar,
  output logic       remover,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] step_count,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SENSE   = 4'd1,
    ADVANCE = 4'd2,
    TURN_L  = 4'd3,
    TURN_R  = 4'd4,
    REMOVE  = 4'd5,
    WAIT    = 4'd6,
    DONE    = 4'd7
  } state_t;

  localparam logic [7:0] STEP_LIMIT   = 8'(MAX_STEPS);
  localparam logic [7:0] REM_LIMIT_M1 = 8'(MAX_REMOVE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic       last_left;
  logic [1:0] turn_cnt;
  logic [7:0] rem_cnt;
  logic       stop_pending;
  logic       sense_go;

`ifdef ROBOT_CTRL_SINGLE_STEP_EN
  assign sense_go = step;
`else
  assign sense_go = 1'b1;
`endif

  // State register
  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decision; sensors only matter in SENSE (and barrier in REMOVE)
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) next_state = SENSE;
      end
      SENSE: begin
        if (sense_go) begin
          if (under_in)                     next_state = DONE;
          else if (barrier_in)              next_state = REMOVE;
          else if (!left_in && !last_left)  next_state = TURN_L;
          else if (!head_in)                next_state = ADVANCE;
          else                              next_state = TURN_R;
        end
      end
      ADVANCE: next_state = WAIT;
      TURN_L:  next_state = WAIT;
      TURN_R:  next_state = WAIT;
      REMOVE: begin
        if (!barrier_in)                 next_state = WAIT;
        else if (rem_cnt == REM_LIMIT_M1) next_state = DONE;
      end
      // WAIT doubles as the gap between right-turn pulses: turn_cnt of 1 or 2
      // means more quarter turns are still owed before returning to SENSE.
      WAIT: begin
        if (stop_pending)                         next_state = DONE;
        else if (turn_cnt == 2'd1 || turn_cnt == 2'd2) next_state = TURN_R;
        else                                      next_state = SENSE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Run bookkeeping: step counter, memory of the last left turn, turn/remove counters
  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) begin
      step_count   <= '0;
      timeout      <= 1'b0;
      last_left    <= 1'b0;
      turn_cnt     <= '0;
      rem_cnt      <= '0;
      stop_pending <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            step_count   <= '0;
            timeout      <= 1'b0;
            last_left    <= 1'b0;
            turn_cnt     <= '0;
            stop_pending <= 1'b0;
          end
        end
        SENSE: begin
          if (next_state == ADVANCE) begin
            if (step_count != 8'hFF) step_count <= step_count + 8'd1;
            last_left <= 1'b0;
          end
          if (next_state == TURN_L) last_left <= 1'b1;
          if (next_state == REMOVE) rem_cnt <= '0;
        end
        ADVANCE: begin
          if (step_count == STEP_LIMIT) begin
            stop_pending <= 1'b1;
            timeout      <= 1'b1;
          end
        end
        TURN_R: turn_cnt <= turn_cnt + 2'd1;
        REMOVE: begin
          if (barrier_in) begin
            if (rem_cnt == REM_LIMIT_M1) timeout <= 1'b1;
            else                         rem_cnt <= rem_cnt + 8'd1;
          end
        end
        WAIT: begin
          if (turn_cnt == 2'd3) begin
            turn_cnt  <= '0;
            last_left <= 1'b0;
          end
          stop_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Registered command and status outputs, decoded from the state being entered
  always_ff @(posedge Clock50 or posedge Reset) begin
    if (Reset) begin
      avancar   <= 1'b0;
      girar     <= 1'b0;
      remover   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_dbg <= '0;
    end else begin
      avancar   <= (next_state == ADVANCE);
      girar     <= (next_state == TURN_L) || (next_state == TURN_R);
      remover   <= (next_state == REMOVE);
      busy      <= (next_state != IDLE) && (next_state != DONE);
      done      <= (next_state == DONE);
      state_dbg <= next_state;
    end
  end

endmodule

// File: tb/tb_robot_controller.sv
// Scoreboard bench for robot_controller: two instances (default limits and
// MAX_STEPS=3 / MAX_REMOVE_CYCLES=4) share sensor inputs but have separate
// start lines. Expected command/done events are queued per instance and
// popped by monitors whenever an instance shows a command or a rising done.
module tb_robot_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
`ifdef ROBOT_CTRL_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  logic       avancar_a, girar_a, remover_a, busy_a, done_a, timeout_a;
  logic [7:0] step_count_a;
  logic [3:0] state_dbg_a;
  logic       avancar_b, girar_b, remover_b, busy_b, done_b, timeout_b;
  logic [7:0] step_count_b;
  logic [3:0] state_dbg_b;

  robot_controller dut_a (
    .Clock50(clk), .Reset(rst), .start(start_a),
`ifdef ROBOT_CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .head_in(head), .left_in(left), .under_in(under), .barrier_in(barrier),
    .avancar(avancar_a), .girar(girar_a), .remover(remover_a), .busy(busy_a),
    .done(done_a), .timeout(timeout_a), .step_count(step_count_a),
    .state_dbg(state_dbg_a)
  );

  robot_controller #(.MAX_STEPS(3), .MAX_REMOVE_CYCLES(4)) dut_b (
    .Clock50(clk), .Reset(rst), .start(start_b),
`ifdef ROBOT_CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .head_in(head), .left_in(left), .under_in(under), .barrier_in(barrier),
    .avancar(avancar_b), .girar(girar_b), .remover(remover_b), .busy(busy_b),
    .done(done_b), .timeout(timeout_b), .step_count(step_count_b),
    .state_dbg(state_dbg_b)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned t0 = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] rel;
    logic [2:0]  cmd;   // {avancar, girar, remover}
    logic        done;
    logic        timeout;
    logic [7:0]  steps;
  } evt_t;

  localparam logic [2:0] ADV = 3'b100;
  localparam logic [2:0] GIR = 3'b010;
  localparam logic [2:0] REM = 3'b001;
  localparam logic [2:0] NON = 3'b000;

  evt_t qa[$];
  evt_t qb[$];

  function automatic evt_t mk(int unsigned r, logic [2:0] c, logic d, logic t, int unsigned s);
    evt_t e;
    e.rel     = 16'(r);
    e.cmd     = c;
    e.done    = d;
    e.timeout = t;
    e.steps   = 8'(s);
    return e;
  endfunction

  task automatic check_evt(input string name, input bit is_b, input evt_t got);
    evt_t exp;
    int   sz;
    checks++;
    sz = is_b ? qb.size() : qa.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL %s unexpected event: rel=%0d cmd=%b done=%b timeout=%b steps=%0d, required no event",
               name, got.rel, got.cmd, got.done, got.timeout, got.steps);
    end else begin
      exp = is_b ? qb.pop_front() : qa.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s event: got rel=%0d cmd=%b done=%b timeout=%b steps=%0d, required rel=%0d cmd=%b done=%b timeout=%b steps=%0d",
                 name, got.rel, got.cmd, got.done, got.timeout, got.steps,
                 exp.rel, exp.cmd, exp.done, exp.timeout, exp.steps);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Monitors: a command high or a rising done is an event to score
  logic done_prev_a = 1'b0;
  logic done_prev_b = 1'b0;

  always @(posedge clk) begin
    #1;
    if ({avancar_a, girar_a, remover_a} != 3'b000 || (done_a && !done_prev_a))
      check_evt("dut_a", 1'b0, mk(cyc - t0, {avancar_a, girar_a, remover_a}, done_a, timeout_a, step_count_a));
    done_prev_a = done_a;
  end

  always @(posedge clk) begin
    #1;
    if ({avancar_b, girar_b, remover_b} != 3'b000 || (done_b && !done_prev_b))
      check_evt("dut_b", 1'b1, mk(cyc - t0, {avancar_b, girar_b, remover_b}, done_b, timeout_b, step_count_b));
    done_prev_b = done_b;
  end

  task automatic wait_rel(input int unsigned r);
    while (cyc - t0 < r) @(negedge clk);
  endtask

  task automatic go(input bit use_b);
    @(negedge clk);
    t0 = cyc;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state_a", 32'(state_dbg_a), 0);
    chk("rst_outs_a", 32'({avancar_a, girar_a, remover_a, busy_a, done_a, timeout_a}), 0);
    chk("rst_steps_a", 32'(step_count_a), 0);
    chk("rst_state_b", 32'(state_dbg_b), 0);
    chk("rst_outs_b", 32'({avancar_b, girar_b, remover_b, busy_b, done_b, timeout_b}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Open corridor: avancar at 2, then every 3 cycles; stop on target
    head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
    qa.push_back(mk(2, ADV, 0, 0, 1));
    qa.push_back(mk(5, ADV, 0, 0, 2));
    qa.push_back(mk(8, ADV, 0, 0, 3));
    qa.push_back(mk(11, NON, 1, 0, 3));
    go(1'b0);
    wait_rel(3);
    chk("corridor_busy", 32'(busy_a), 1);
    wait_rel(9);
    under = 1'b1;
    wait_rel(14);
    chk("corridor_drained", 32'(qa.size()), 0);

    // Left opening: one left turn, last_left then forces an advance
    under = 1'b0; left = 1'b0; head = 1'b0;
    qa.push_back(mk(2, GIR, 0, 0, 0));
    qa.push_back(mk(5, ADV, 0, 0, 1));
    qa.push_back(mk(8, NON, 1, 0, 1));
    go(1'b0);
    wait_rel(6);
    under = 1'b1;
    wait_rel(11);
    chk("left_drained", 32'(qa.size()), 0);

    // Dead end: right turn as three left pulses with gaps, then SENSE
    under = 1'b0; head = 1'b1; left = 1'b1;
    qa.push_back(mk(2, GIR, 0, 0, 0));
    qa.push_back(mk(4, GIR, 0, 0, 0));
    qa.push_back(mk(6, GIR, 0, 0, 0));
    qa.push_back(mk(9, NON, 1, 0, 0));
    go(1'b0);
    wait_rel(7);
    under = 1'b1;
    wait_rel(8);
    chk("turn_r_back_to_sense", 32'(state_dbg_a), 1);
    wait_rel(12);
    chk("turn_r_drained", 32'(qa.size()), 0);

    // Reset in the middle of a right turn
    under = 1'b0; head = 1'b1; left = 1'b1;
    qa.push_back(mk(2, GIR, 0, 0, 0));
    go(1'b0);
    wait_rel(2);
    rst = 1'b1;
    #1;
    chk("midturn_rst_outs", 32'({avancar_a, girar_a, remover_a, busy_a, done_a, timeout_a}), 0);
    chk("midturn_rst_state", 32'(state_dbg_a), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_rel(12);
    chk("midturn_no_more_pulses", 32'(qa.size()), 0);
    chk("midturn_idle", 32'(state_dbg_a), 0);

    // Obstacle cleared after 9 remover cycles, then advance resumes
    barrier = 1'b1; head = 1'b0; left = 1'b1; under = 1'b0;
    for (int unsigned r = 2; r <= 10; r++) qa.push_back(mk(r, REM, 0, 0, 0));
    qa.push_back(mk(13, ADV, 0, 0, 1));
    qa.push_back(mk(16, NON, 1, 0, 1));
    go(1'b0);
    wait_rel(10);
    barrier = 1'b0;
    wait_rel(14);
    under = 1'b1;
    wait_rel(19);
    chk("remove_drained", 32'(qa.size()), 0);

    // Step budget of 3 on an open corridor
    under = 1'b0; barrier = 1'b0; head = 1'b0; left = 1'b1;
    qb.push_back(mk(2, ADV, 0, 0, 1));
    qb.push_back(mk(5, ADV, 0, 0, 2));
    qb.push_back(mk(8, ADV, 0, 0, 3));
    qb.push_back(mk(10, NON, 1, 1, 3));
    go(1'b1);
    wait_rel(13);
    chk("budget_drained", 32'(qb.size()), 0);
    chk("budget_timeout", 32'(timeout_b), 1);
    chk("budget_steps", 32'(step_count_b), 3);
    chk("budget_busy", 32'(busy_b), 0);

    // Stuck obstacle: abort after 4 remover cycles
    barrier = 1'b1;
    for (int unsigned r = 2; r <= 5; r++) qb.push_back(mk(r, REM, 0, 0, 0));
    qb.push_back(mk(6, NON, 1, 1, 0));
    go(1'b1);
    wait_rel(9);
    chk("stuck_drained", 32'(qb.size()), 0);

    // Target under the robot at first SENSE
    barrier = 1'b0; under = 1'b1;
    qb.push_back(mk(2, NON, 1, 0, 0));
    go(1'b1);
    wait_rel(5);
    chk("target_drained", 32'(qb.size()), 0);
    chk("target_timeout", 32'(timeout_b), 0);
    chk("target_steps", 32'(step_count_b), 0);
    chk("idle_a_quiet", 32'(qa.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/robot_controller.md
Name: robot_controller

Overview:
- Autonomous left-hand wall-follower FSM that drives the map/robot datapath.
- Consumes the map's sensor flags (head, left, under, barrier) and issues one-cycle advance/rotate commands plus a held remove command.
- Clocked by the same clock that steps the map, so each command is consumed by the map on the next edge.
- Stops when the robot stands on the black target cell or exhausts its step budget.

Parameters:
- MAX_STEPS, 255: advance pulses allowed before a forced stop (1..255).
- MAX_REMOVE_CYCLES, 15: cycles remover may be held before the obstacle is abandoned (1..255).

Ports:
- Clock50  input  1  controller/robot clock (map step clock)
- Reset  input  1  asynchronous, active-high reset
- start  input  1  begin run; sampled in IDLE or DONE only
- head_in  input  1  wall/edge directly ahead
- left_in  input  1  wall/edge to robot's left
- under_in  input  1  robot is on the black target cell
- barrier_in  input  1  trash obstacle directly ahead
- avancar  output  1  advance one cell (1-cycle pulse)
- girar  output  1  rotate 90° counter-clockwise, i.e. turn left (1-cycle pulse)
- remover  output  1  remove obstacle ahead (level, held)
- busy  output  1  run in progress
- done  output  1  run finished (level)
- timeout  output  1  run ended by MAX_STEPS or remove abort
- step_count  output  8  advance pulses issued this run, saturating
- state_dbg  output  4  current state encoding

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; last_left=0; step_count=0; turn counter and remove counter 0. Reset mid-turn or mid-remove aborts with no further pulses.
- All outputs are registered. Only one of avancar/girar/remover is high in any cycle.
- Encodings: IDLE=0, SENSE=1, ADVANCE=2, TURN_L=3, TURN_R=4, REMOVE=5, WAIT=6, DONE=7.
- IDLE: start=1 -> SENSE; clear step_count, timeout, last_left. busy=1 in every state except IDLE and DONE.
- SENSE evaluates the sensors, first match wins:
  1. under_in -> DONE.
  2. barrier_in -> REMOVE.
  3. !left_in && !last_left -> TURN_L.
  4. !head_in -> ADVANCE.
  5. otherwise -> TURN_R.
- ADVANCE:
  - avancar=1 for one cycle; step_count+1, saturating at 255; last_left=0.
  - If the new step_count equals MAX_STEPS: timeout=1, go to DONE (via WAIT). Otherwise go to WAIT.
- TURN_L: girar=1 for one cycle; last_left=1; -> WAIT -> SENSE.
- TURN_R:
  - Three girar pulses (3 × 90° left = right turn), each followed by one WAIT cycle; sequence is girar,0,girar,0,girar,0 (6 cycles).
  - A 2-bit counter tracks the pulses. last_left=0 on completion, then -> SENSE.
- REMOVE:
  - remover held high; remove counter increments each cycle.
  - barrier_in=0 sampled -> remover=0, -> WAIT -> SENSE.
  - Counter reaches MAX_REMOVE_CYCLES with barrier_in still 1 -> remover=0, timeout=1, -> DONE.
- WAIT: all commands 0 for exactly one cycle so map sensors settle before the next SENSE. Every command is therefore followed by at least one idle cycle.
- DONE:
  - done=1, busy=0, outputs otherwise 0; step_count holds.
  - start=1 restarts exactly as from IDLE (done and timeout clear on the transition).
- Sensor inputs are sampled only in SENSE (and barrier_in in REMOVE); changes elsewhere are ignored.

Optional Feature:
- Macro ROBOT_CTRL_SINGLE_STEP_EN.
- With it defined: adds input step (1 bit). SENSE holds until step=1; one decision plus its full command sequence runs per step pulse. step is ignored outside SENSE.
- Without it: no step port; SENSE decides every time it is entered.

Test Plan:
- Reset during TURN_R after the first girar pulse -> all outputs 0 immediately; state_dbg=0; no further girar pulses after release.
- start, head_in=0, left_in=1, others 0 -> avancar pulse 2 cycles after start, then one per 3 cycles (SENSE, ADVANCE, WAIT); step_count 0->1->2.
- start, left_in=0 -> single girar, then with left_in still 0 and head_in=0 -> avancar (last_left blocks a second left turn); step_count=1.
- head_in=1, left_in=1 -> girar pattern 1,0,1,0,1,0 over 6 cycles, then SENSE; no avancar.
- barrier_in=1 and released after 9 cycles of remover -> remover high exactly 9 cycles, then advance resumes. With MAX_REMOVE_CYCLES=4 and barrier_in stuck at 1 -> remover high 4 cycles, done=1, timeout=1.
- MAX_STEPS=3, open corridor -> exactly 3 avancar pulses, done=1, timeout=1, step_count=3. Separately, under_in=1 at first SENSE -> done=1, timeout=0, step_count=0.
